cle_label_stats: RTL



---
 rtl/cle_pkg.sv | 26 ++
 rtl/cle_label_stats_if.sv | 32 +++
 rtl/cle_stats_slot.sv | 49 ++++
 rtl/cle_label_stats.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// Shared types and sizes for the CLE post-labeling statistics stage.
// Slot contents and the scan FSM encoding live here so every file agrees on widths.
package cle_pkg;

  localparam int unsigned MAX_OBJ = 8;
  localparam int unsigned IMG_W   = 32;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned LABEL_W = 8;
  localparam int unsigned AREA_W  = 11;
  localparam int unsigned COORD_W = $clog2(IMG_W);
  localparam int unsigned IDX_W   = $clog2(MAX_OBJ);
  localparam int unsigned CNT_W   = $clog2(MAX_OBJ) + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  typedef struct packed {
    logic               valid;
    logic [LABEL_W-1:0] label;
    logic [AREA_W-1:0]  area;
    logic [COORD_W-1:0] rmin;
    logic [COORD_W-1:0] rmax;
    logic [COORD_W-1:0] cmin;
    logic [COORD_W-1:0] cmax;
  } slot_t;

endpackage

// File: rtl/cle_label_stats_if.sv
// Control, label-SRAM read port and result readout of the statistics stage.
// slave is the statistics block; master is the host/CLE side.
interface cle_label_stats_if;
  import cle_pkg::*;

  logic               start;
  logic [ADDR_W-1:0]  sram_a;
  logic [LABEL_W-1:0] sram_q;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   obj_count;
  logic               overflow;
  logic [IDX_W-1:0]   res_idx;
  logic [LABEL_W-1:0] res_label;
  logic [AREA_W-1:0]  res_area;
  logic [COORD_W-1:0] res_rmin;
  logic [COORD_W-1:0] res_rmax;
  logic [COORD_W-1:0] res_cmin;
  logic [COORD_W-1:0] res_cmax;

  modport slave (
    input  start, sram_q, res_idx,
    output sram_a, busy, done, obj_count, overflow,
    output res_label, res_area, res_rmin, res_rmax, res_cmin, res_cmax
  );

  modport master (
    output start, sram_q, res_idx,
    input  sram_a, busy, done, obj_count, overflow,
    input  res_label, res_area, res_rmin, res_rmax, res_cmin, res_cmax
  );
endinterface

// File: rtl/cle_stats_slot.sv
// One object-table entry: label, pixel area and bounding box.
// hit compares against the registered label, so an allocation is visible one pixel later.
module cle_stats_slot
  import cle_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               pix_vld,
  input  logic [LABEL_W-1:0] pix_label,
  input  logic [COORD_W-1:0] pix_row,
  input  logic [COORD_W-1:0] pix_col,
  input  logic               alloc,
  output logic               hit,
  output slot_t              slot
);

  slot_t slot_q, slot_d;

  assign hit  = slot_q.valid && (slot_q.label == pix_label);
  assign slot = slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (alloc) begin
      slot_d.valid = 1'b1;
      slot_d.label = pix_label;
      slot_d.area  = AREA_W'(1);
      slot_d.rmin  = pix_row;
      slot_d.rmax  = pix_row;
      slot_d.cmin  = pix_col;
      slot_d.cmax  = pix_col;
    end else if (pix_vld && hit) begin
      slot_d.area = slot_q.area + AREA_W'(1);
      if (pix_row < slot_q.rmin) slot_d.rmin = pix_row;
      if (pix_row > slot_q.rmax) slot_d.rmax = pix_row;
      if (pix_col < slot_q.cmin) slot_d.cmin = pix_col;
      if (pix_col > slot_q.cmax) slot_d.cmax = pix_col;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

endmodule

// File: rtl/cle_label_stats.sv
// Raster-scans the 32x32 label SRAM after CLE finishes and builds a per-label table
// of area and bounding box; slots fill in order of first raster appearance.
module cle_label_stats
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cle_label_stats_if.slave  bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic [ADDR_W-1:0]   pix_addr_q;
  logic                pix_vld_q;
  logic [CNT_W-1:0]    obj_count_q;
  logic                overflow_q;
  logic                clear;
  logic                pix_act;
  logic                miss;
  logic                full;
  logic                found;
  logic [MAX_OBJ-1:0]  hit_vec;
  logic [MAX_OBJ-1:0]  valid_vec;
  logic [MAX_OBJ-1:0]  alloc_vec;
  slot_t               slots [MAX_OBJ];

  assign clear = ((state_q == StIdle) || (state_q == StDone)) && bus.start;

  always_comb begin
    state_d  = state_q;
    sram_a_d = sram_a_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StScan;
          sram_a_d = '0;
        end
      end
      StScan: begin
        if (sram_a_q == '1) state_d  = StDrain;
        else                sram_a_d = sram_a_q + ADDR_W'(1);
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // sram_q during a cycle belongs to the address issued one cycle earlier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      sram_a_q   <= '0;
      pix_addr_q <= '0;
      pix_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sram_a_q   <= sram_a_d;
      pix_addr_q <= sram_a_q;
      pix_vld_q  <= (state_q == StScan);
    end
  end

  assign pix_act = pix_vld_q && (bus.sram_q != '0);
  assign miss    = pix_act && !(|hit_vec);
  assign full    = &valid_vec;

  // Lowest free slot wins the allocation
  always_comb begin
    alloc_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      if (!valid_vec[i] && !found) begin
        alloc_vec[i] = miss;
        found        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < MAX_OBJ; g++) begin : g_slot
    cle_stats_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .pix_vld   (pix_act),
      .pix_label (bus.sram_q),
      .pix_row   (pix_addr_q[ADDR_W-1 -: COORD_W]),
      .pix_col   (pix_addr_q[COORD_W-1:0]),
      .alloc     (alloc_vec[g]),
      .hit       (hit_vec[g]),
      .slot      (slots[g])
    );
    assign valid_vec[g] = slots[g].valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obj_count_q <= '0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      obj_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (|alloc_vec)    obj_count_q <= obj_count_q + CNT_W'(1);
      if (miss && full)  overflow_q  <= 1'b1;
    end
  end

  assign bus.sram_a    = sram_a_q;
  assign bus.busy      = (state_q == StScan) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.obj_count = obj_count_q;
  assign bus.overflow  = overflow_q;
  assign bus.res_label = slots[bus.res_idx].label;
  assign bus.res_area  = slots[bus.res_idx].area;
  assign bus.res_rmin  = slots[bus.res_idx].rmin;
  assign bus.res_rmax  = slots[bus.res_idx].rmax;
  assign bus.res_cmin  = slots[bus.res_idx].cmin;
  assign bus.res_cmax  = slots[bus.res_idx].cmax;

endmodule
